// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin request/grant arbiter.
// rr_pick is a loop-based reference for the same pick that rr_pick_comb builds structurally.
package arb_pkg;

    localparam int DEFAULT_N_REQ    = 4;
    localparam int DEFAULT_MAX_HOLD = 8;
    localparam int PICK_MAX_N       = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } pick_t;

    // First set bit of req scanning ptr, ptr+1, ... cyclically over n requesters.
    function automatic pick_t rr_pick(input logic [PICK_MAX_N-1:0] req,
                                      input logic [3:0]            ptr,
                                      input int                    n);
        pick_t res;
        int    i;
        res = '0;
        for (int k = PICK_MAX_N - 1; k >= 0; k--) begin
            if (k < n) begin
                i = (int'(ptr) + k) % n;
                if (req[4'(i)]) begin
                    res.found = 1'b1;
                    res.idx   = 4'(i);
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// Combinational round-robin pick: rotate req so ptr sits at bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module rr_pick_comb #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             found,
    output logic [ID_W-1:0]  idx
);

    localparam int            SUM_W = ID_W + 1;
    localparam logic [ID_W:0] N_L   = SUM_W'(N_REQ);

    logic [N_REQ-1:0] rot;
    logic [ID_W-1:0]  off;
    logic [ID_W:0]    sum;

    always_comb begin
        rot = N_REQ'({req, req} >> ptr);
        off = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = ID_W'(j);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= N_L) begin
            sum = sum - N_L;
        end
        idx   = sum[ID_W-1:0];
        found = |req;
    end

endmodule

// File: rtl/rr_req_gnt_arbiter.sv
// Round-robin arbiter with bounded grant tenure: a holder keeps the resource while
// its req stays high, and is preempted after MAX_HOLD cycles only if someone else waits.
module rr_req_gnt_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = DEFAULT_N_REQ,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
    parameter int ID_W     = $clog2(N_REQ),
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [ID_W-1:0]  gnt_id,
    output logic [CNT_W-1:0] hold_cnt
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_REQ - 1);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;

    logic [ID_W-1:0]  next_ptr;
    logic [ID_W-1:0]  pick_ptr;
    logic             pick_found;
    logic [ID_W-1:0]  pick_idx;
    logic             holder_req;
    logic             others_req;

    // While granted, every hand-off scans from just past the holder; the holder's own
    // bit is either low (release) or reached last, so the same pick serves both paths.
    assign next_ptr   = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + 1'b1;
    assign pick_ptr   = (state_q == GRANT) ? next_ptr : ptr_q;
    assign holder_req = |(req & gnt_q);
    assign others_req = |(req & ~gnt_q);

    rr_pick_comb #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        hold_cnt_d  = hold_cnt_q;
        ptr_d       = ptr_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = GRANT;
                    gnt_d       = N_REQ'(1) << pick_idx;
                    gnt_valid_d = 1'b1;
                    gnt_id_d    = pick_idx;
                    hold_cnt_d  = CNT_W'(1);
                end
            end
            GRANT: begin
                if (!holder_req) begin
                    ptr_d = next_ptr;
                    if (pick_found) begin
                        gnt_d      = N_REQ'(1) << pick_idx;
                        gnt_id_d   = pick_idx;
                        hold_cnt_d = CNT_W'(1);
                    end else begin
                        state_d     = IDLE;
                        gnt_d       = '0;
                        gnt_valid_d = 1'b0;
                        gnt_id_d    = '0;
                        hold_cnt_d  = '0;
                    end
                end else if ((hold_cnt_q == MAX_CNT) && others_req) begin
                    ptr_d      = next_ptr;
                    gnt_d      = N_REQ'(1) << pick_idx;
                    gnt_id_d   = pick_idx;
                    hold_cnt_d = CNT_W'(1);
                end else if (hold_cnt_q != MAX_CNT) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            hold_cnt_q  <= '0;
            ptr_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            hold_cnt_q  <= hold_cnt_d;
            ptr_q       <= ptr_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;
    assign hold_cnt  = hold_cnt_q;

    // An idle arbiter seeing any request must grant on the next cycle.
    a_idle_grants: assert property (@(posedge clk) disable iff (rst)
        (state_q == IDLE && req != '0) |=> gnt_valid_q);

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));

endmodule

// File: tb/tb_rr_req_gnt_arbiter.sv
// Bench for rr_req_gnt_arbiter: directed scenarios with literal expectations,
// then random traffic compared every cycle against a behavioural model.
module tb_rr_req_gnt_arbiter;

    localparam int N   = 4;
    localparam int MH  = 8;
    localparam int FAIR_BOUND = (N - 1) * MH + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic [3:0] hold_cnt;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    // Behavioural model state: holder index (-1 = none), tenure, priority pointer.
    int         m_holder = -1;
    int         m_cnt    = 0;
    int         m_ptr    = 0;
    logic [3:0] m_prev_req = '0;
    int         wait_c[N];

    rr_req_gnt_arbiter #(
        .N_REQ    (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .hold_cnt  (hold_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        m_prev_req = req;
        if (rst) begin
            m_holder = -1;
            m_cnt    = 0;
            m_ptr    = 0;
        end else if (m_holder < 0) begin
            m_holder = m_pick(req, m_ptr);
            m_cnt    = (m_holder >= 0) ? 1 : 0;
        end else if (!req[m_holder]) begin
            m_ptr    = (m_holder + 1) % N;
            m_holder = m_pick(req, m_ptr);
            m_cnt    = (m_holder >= 0) ? 1 : 0;
        end else if (m_cnt == MH && (req & ~(4'b1 << m_holder)) != 4'b0) begin
            m_ptr    = (m_holder + 1) % N;
            m_holder = m_pick(req, m_ptr);
            m_cnt    = 1;
        end else if (m_cnt < MH) begin
            m_cnt = m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        logic [3:0] exp_gnt;
        int         worst;
        if (chk_on) begin
            exp_gnt = (m_holder >= 0) ? (4'b1 << m_holder) : 4'b0;
            chk("mdl_gnt", gnt, exp_gnt);
            chk("mdl_valid", gnt_valid, (m_holder >= 0) ? 1 : 0);
            chk("mdl_id", gnt_id, (m_holder >= 0) ? m_holder : 0);
            chk("mdl_hold", hold_cnt, m_cnt);
            chk("gnt_without_req", gnt & ~m_prev_req, 0);
            worst = 0;
            for (int i = 0; i < N; i++) begin
                if (!rst && req[i] && !gnt[i]) wait_c[i]++;
                else wait_c[i] = 0;
                if (wait_c[i] > worst) worst = wait_c[i];
            end
            chk("fair_wait_over_bound", (worst > FAIR_BOUND) ? worst : 0, 0);
        end
    end

    task automatic step(input logic [3:0] r, input logic rs);
        req = r;
        rst = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [3:0] g, input int id, input int hc);
        chk({name, "_gnt"}, gnt, g);
        chk({name, "_valid"}, gnt_valid, (g != 4'b0) ? 1 : 0);
        chk({name, "_id"}, gnt_id, id);
        chk({name, "_hold"}, hold_cnt, hc);
    endtask

    task automatic do_reset();
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
    endtask

    initial begin
        logic [3:0] r;
        for (int i = 0; i < N; i++) wait_c[i] = 0;
        req = '0;
        rst = 1'b1;
        do_reset();
        chk_on = 1'b1;
        expect_out("reset", 4'b0000, 0, 0);

        // Single requester: grant one cycle after req, tenure counts up.
        for (int k = 1; k <= 3; k++) begin
            step(4'b0001, 1'b0);
            expect_out($sformatf("single_%0d", k), 4'b0001, 0, k);
        end
        step(4'b0000, 1'b0);
        expect_out("single_drop", 4'b0000, 0, 0);

        // Contention from reset: ptr=0 picks 1, release hands straight to 3.
        do_reset();
        step(4'b1010, 1'b0);
        expect_out("cont_first", 4'b0010, 1, 1);
        step(4'b1010, 1'b0);
        step(4'b1000, 1'b0);
        expect_out("cont_handoff", 4'b1000, 3, 1);

        // Preemption between two persistent requesters every MAX_HOLD cycles.
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            step(4'b0011, 1'b0);
            expect_out($sformatf("preempt_%0d", k),
                       (((k - 1) / MH) % 2 == 0) ? 4'b0001 : 4'b0010,
                       ((k - 1) / MH) % 2, ((k - 1) % MH) + 1);
        end

        // Sole holder is never preempted; counter saturates.
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            step(4'b0100, 1'b0);
            expect_out($sformatf("sole_%0d", k), 4'b0100, 2, (k < MH) ? k : MH);
        end

        // Reset mid-grant clears the pointer as well as the grant.
        do_reset();
        step(4'b0010, 1'b0);
        step(4'b0100, 1'b0);
        expect_out("rst_pre", 4'b0100, 2, 1);
        step(4'b0100, 1'b1);
        expect_out("rst_mid", 4'b0000, 0, 0);
        step(4'b1010, 1'b0);
        expect_out("rst_after", 4'b0010, 1, 1);

        // Pointer wrap from requester 3 back to 0.
        do_reset();
        step(4'b1000, 1'b0);
        expect_out("wrap_hold3", 4'b1000, 3, 1);
        step(4'b0001, 1'b0);
        expect_out("wrap_to0", 4'b0001, 0, 1);
        step(4'b1000, 1'b0);
        expect_out("wrap_back3", 4'b1000, 3, 1);

        // Random traffic: requests persist for a while, occasional resets.
        r = 4'b0000;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 11) == 0) r[i] = ~r[i];
            end
            step(r, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
        end
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
